// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scan load/unload controller.
package scan_ctrl_pkg;

  localparam int DEF_CHAIN_LEN      = 8;
  localparam int DEF_CAPTURE_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/scan_shift_counter.sv
// Loadable down-counter; zero_o flags the edge on which the count reaches zero.
module scan_shift_counter #(
  parameter int W = 4
) (
  input  logic         CK,
  input  logic         RN,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  assign zero_o = dec_i && (cnt_q == W'(1));

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_load_unload_ctrl.sv
// Shifts parallel patterns into a scan chain, runs capture, and shifts the
// response back out; the unload of one pattern overlaps the load of the next.
module scan_load_unload_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = DEF_CHAIN_LEN,
  parameter int CAPTURE_CYCLES = DEF_CAPTURE_CYCLES
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_last,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 chain_ck_en,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int CAP_W = $clog2(CAPTURE_CYCLES + 1);

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] shift_q, shift_d;
  logic [CHAIN_LEN-1:0] resp_shift_q, resp_shift_d;
  logic [CHAIN_LEN-1:0] resp_data_q, resp_data_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 last_q, last_d;
  logic                 pend_q, pend_d;
  logic                 uo_q, uo_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 ck_en_q, ck_en_d;
  logic                 busy_q, busy_d;

  logic sh_load, sh_dec, sh_zero;
  logic cap_load, cap_dec, cap_zero;
  logic resp_free;

  assign resp_free = !resp_valid_q || resp_ready;

  // A pending response may only be unloaded into a free buffer; after the
  // final pattern the IDLE slot is reserved for the unload-only shift.
  assign pat_ready = RN && (state_q == IDLE) &&
                     (!pend_q || (resp_free && !last_q));

  scan_shift_counter #(.W(CNT_W)) u_shift_cnt (
    .CK         (CK),
    .RN         (RN),
    .load_i     (sh_load),
    .load_val_i (CNT_W'(CHAIN_LEN)),
    .dec_i      (sh_dec),
    .zero_o     (sh_zero)
  );

  scan_shift_counter #(.W(CAP_W)) u_cap_cnt (
    .CK         (CK),
    .RN         (RN),
    .load_i     (cap_load),
    .load_val_i (CAP_W'(CAPTURE_CYCLES)),
    .dec_i      (cap_dec),
    .zero_o     (cap_zero)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    resp_shift_d = resp_shift_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q && !resp_ready;
    last_d       = last_q;
    pend_d       = pend_q;
    uo_d         = uo_q;
    sh_load      = 1'b0;
    sh_dec       = 1'b0;
    cap_load     = 1'b0;
    cap_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pat_valid && pat_ready) begin
          shift_d = pat_data;
          last_d  = pat_last;
          sh_load = 1'b1;
          state_d = SHIFT;
        end else if (pend_q && last_q && resp_free) begin
          uo_d    = 1'b1;
          shift_d = '0;
          sh_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d      = shift_q >> 1;
        resp_shift_d = {scan_so, resp_shift_q[CHAIN_LEN-1:1]};
        sh_dec       = 1'b1;
        if (sh_zero) begin
          if (pend_q) begin
            resp_data_d  = resp_shift_d;
            resp_valid_d = 1'b1;
            pend_d       = 1'b0;
          end
          if (uo_q) begin
            uo_d    = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cap_load = 1'b1;
            state_d  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        cap_dec = 1'b1;
        if (cap_zero) begin
          pend_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Chain-facing outputs are registered from the next state so they line
    // up with the cycle the state register enters.
    se_d    = (state_d == SHIFT);
    si_d    = (state_d == SHIFT) && shift_d[0];
    ck_en_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE) || pend_d;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      resp_shift_q <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      last_q       <= 1'b0;
      pend_q       <= 1'b0;
      uo_q         <= 1'b0;
      se_q         <= 1'b0;
      si_q         <= 1'b0;
      ck_en_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      resp_shift_q <= resp_shift_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      last_q       <= last_d;
      pend_q       <= pend_d;
      uo_q         <= uo_d;
      se_q         <= se_d;
      si_q         <= si_d;
      ck_en_q      <= ck_en_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign scan_se     = se_q;
  assign scan_si     = si_q;
  assign chain_ck_en = ck_en_q;
  assign busy        = busy_q;

endmodule
